// File: rtl/gigatron_ram_loader_pkg.sv
// Shared encodings for the Gigatron RAM loader: host command ops and FSM states.
// The host bridge imports the same op constants.
`timescale 1ns/1ps
package gigatron_ram_loader_pkg;

    typedef enum logic [1:0] {
        OP_SETADDR = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_NOP     = 2'b11
    } cmd_op_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RD_CAP  = 2'd2;
    localparam logic [1:0] ST_RD_HOLD = 2'd3;

endpackage

// File: rtl/gigatron_ram_loader_if.sv
// Command/response streams plus RAM port bundle between host side and loader.
// The slave modport is the loader; master is the host/RAM side.
`timescale 1ns/1ps
interface gigatron_ram_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [1:0]            i_cmd_op;
    logic [ADDR_WIDTH-1:0] i_cmd_data;

    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [7:0]            o_rsp_data;
    logic                  o_rsp_last;

    logic [ADDR_WIDTH-1:0] o_ram_raddr;
    logic [ADDR_WIDTH-1:0] o_ram_waddr;
    logic                  o_ram_we;
    logic [7:0]            o_ram_wdata;
    logic [7:0]            i_ram_rdata;

    logic [ADDR_WIDTH-1:0] o_addr;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready, i_ram_rdata,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_last,
               o_ram_raddr, o_ram_waddr, o_ram_we, o_ram_wdata, o_addr
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready, i_ram_rdata,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_last,
               o_ram_raddr, o_ram_waddr, o_ram_we, o_ram_wdata, o_addr
    );
endinterface

// File: rtl/gigatron_ram_loader.sv
// Command-driven initiator for the Gigatron RAM: SETADDR/WRITE/READ commands in,
// RAM port activity out, read bytes returned on a valid/ready response stream.
`timescale 1ns/1ps
module gigatron_ram_loader
    import gigatron_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    gigatron_ram_loader_if.slave bus
);

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] waddr_q,     waddr_d;
    logic [7:0]            wdata_q,     wdata_d;
    logic                  we_q,        we_d;
    logic [7:0]            rsp_data_q,  rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path leaves one unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    case (cmd_op_e'(bus.i_cmd_op))
                        OP_SETADDR: ptr_d = bus.i_cmd_data;
                        OP_WRITE: begin
                            waddr_d = ptr_q;
                            wdata_d = bus.i_cmd_data[7:0];
                            we_d    = 1'b1;
                            ptr_d   = ptr_q + ADDR_WIDTH'(1);
                            state_d = ST_WRITE;
                        end
                        // The RAM samples ptr on this same edge, so data is ready in RD_CAP.
                        OP_READ: begin
                            remaining_d = bus.i_cmd_data;
                            state_d     = ST_RD_CAP;
                        end
                        OP_NOP: ;
                    endcase
                end
            end
            ST_WRITE: begin
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
            ST_RD_CAP: begin
                rsp_data_d  = bus.i_ram_rdata;
                rsp_valid_d = 1'b1;
                ptr_d       = ptr_q + ADDR_WIDTH'(1);
                state_d     = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                // The extra cycle here lets the RAM sample the incremented pointer.
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - ADDR_WIDTH'(1);
                        state_d     = ST_RD_CAP;
                    end
                end
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values; reset clears
    // all control and output registers, which is what cancels an in-flight we pulse or pending response.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.o_cmd_ready = (state_q == ST_IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_last  = (state_q == ST_RD_HOLD) && (remaining_q == '0);
    assign bus.o_ram_raddr = ptr_q;
    assign bus.o_ram_waddr = waddr_q;
    assign bus.o_ram_we    = we_q;
    assign bus.o_ram_wdata = wdata_q;
    assign bus.o_addr      = ptr_q;

endmodule
